// File: rtl/reg_file_sb.sv
// reg_file_sb: clocked register file with write-first read bypass and a
// per-register busy scoreboard for decode-stage hazard detection.
//
// Ports:
//   clk, rst            clock, async active-high reset
//   wr_en/wr_addr/wr_data   writeback port (write on rising edge)
//   iss_en/iss_addr     issue port, marks destination register pending
//   rd_addr/rd_data     NUM_RD packed combinational read ports
//   rd_busy             per-port pending flag after bypass
//   busy_vec            raw registered scoreboard bits
//
// Optional macro REG_FILE_ZERO_REG_EN hardwires register 0 to zero.
module reg_file_sb #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  output logic [(1<<ADDR_W)-1:0]   busy_vec
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  r_busy;

  logic             w_wr_ok;
  logic             w_iss_ok;
  logic [DEPTH-1:0] w_set;
  logic [DEPTH-1:0] w_clr;
  logic [DEPTH-1:0] w_busy_nxt;

  // Inputs are ignored during reset so the bypass cannot leak wr_data.
`ifdef REG_FILE_ZERO_REG_EN
  assign w_wr_ok  = wr_en & ~rst & (wr_addr != '0);
  assign w_iss_ok = iss_en & ~rst & (iss_addr != '0);
`else
  assign w_wr_ok  = wr_en & ~rst;
  assign w_iss_ok = iss_en & ~rst;
`endif

  // Issue sets beat writeback clears: the newer producer is pending.
  always_comb begin
    w_set      = '0;
    w_clr      = '0;
    if (w_iss_ok) w_set = DEPTH'(1) << iss_addr;
    if (w_wr_ok)  w_clr = DEPTH'(1) << wr_addr;
    w_busy_nxt = (r_busy & ~w_clr) | w_set;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_busy <= '0;
    end else begin
      if (w_wr_ok) r_mem[wr_addr] <= wr_data;
      r_busy <= w_busy_nxt;
    end
  end

  assign busy_vec = r_busy;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_ra;
    logic              w_hit;
    logic              w_zero;

    assign w_ra  = rd_addr[k*ADDR_W +: ADDR_W];
    assign w_hit = w_wr_ok && (wr_addr == w_ra);
`ifdef REG_FILE_ZERO_REG_EN
    assign w_zero = rst | (w_ra == '0);
`else
    assign w_zero = rst;
`endif

    assign rd_data[k*DATA_W +: DATA_W] =
      w_zero ? '0 : (w_hit ? wr_data : r_mem[w_ra]);
    assign rd_busy[k] = r_busy[w_ra] & ~w_hit;
  end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
Parametrised, clocked successor to the team's combinational register file for the pipelined MIPS datapath.
- Synchronous write port.
- NUM_RD combinational read ports with write-first bypass, so the decode stage sees a same-cycle writeback.
- Per-register busy scoreboard: set at issue, cleared at writeback; hazard logic uses it to stall.
- Sits between decode (reads/issue) and writeback (write).

Parameters:
DATA_W, 16, register width in bits
ADDR_W, 3, register index width; depth = 2**ADDR_W
NUM_RD, 2, number of read ports (minimum 1)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
wr_en  input  1  writeback enable
wr_addr  input  ADDR_W  writeback register index
wr_data  input  DATA_W  writeback data
iss_en  input  1  issue: mark iss_addr as pending
iss_addr  input  ADDR_W  destination register of issuing instruction
rd_addr  input  NUM_RD*ADDR_W  read indices; port k uses bits [k*ADDR_W +: ADDR_W]
rd_data  output  NUM_RD*DATA_W  read data; port k uses bits [k*DATA_W +: DATA_W]
rd_busy  output  NUM_RD  port k: addressed register pending after bypass
busy_vec  output  2**ADDR_W  raw scoreboard bits, one per register

Behaviour:
- Reset (async, rst=1): all registers cleared to 0 and all busy bits to 0, immediately and without waiting for a clock edge. While rst=1:
  - rd_data is 0 on every port; rd_busy and busy_vec are 0;
  - wr_en and iss_en are ignored.
- Deassertion of rst is sampled normally; the first write can land on the first rising edge with rst=0.
- Write: on a rising edge with wr_en=1, mem[wr_addr] <= wr_data. One cycle latency to storage.
- Read (combinational, per port k):
  - if wr_en=1 and wr_addr==rd_addr_k, rd_data_k = wr_data (bypass);
  - else rd_data_k = mem[rd_addr_k].
  - Any number of ports may address the same register and see identical data.
- Scoreboard, per register r, on each rising edge:
  - set when iss_en=1 and iss_addr==r;
  - else cleared when wr_en=1 and wr_addr==r;
  - else held.
  - Simultaneous issue and writeback to the same r: set wins (the newer producer is pending). The data write still occurs that edge.
  - Issue to an already-busy register: stays busy (no counting; one outstanding producer per register is guaranteed by hazard logic).
  - Writeback to a non-busy register: data written, busy stays 0.
- rd_busy_k = busy[rd_addr_k] AND NOT (wr_en AND wr_addr==rd_addr_k). A register being written back this cycle reads as not busy, because the bypass supplies its value.
- busy_vec reflects registered busy bits only (no bypass term).
- Widths: no arithmetic. Indices are always in range since depth = 2**ADDR_W. No X propagation from uninitialised storage, because reset clears everything.

Optional Feature:
Macro REG_FILE_ZERO_REG_EN.
- Defined: register 0 is hardwired to zero.
  - Writes with wr_addr=0 are discarded.
  - Reads of index 0 return 0, with no bypass even when wr_en=1 and wr_addr=0.
  - busy[0] is never set, so iss_addr=0 is ignored; rd_busy for index 0 and busy_vec[0] are constant 0.
- Undefined: register 0 is an ordinary register with identical behaviour to all others.

Test Plan:
1. Reset then read: rst pulse; all rd_addr swept 0..7 -> rd_data 0, busy_vec 8'h00; assert rst mid-run after writing 16'hBEEF to r5 -> r5 reads 0 before next clock edge.
2. Write/readback: wr_en=1, wr_addr=3, wr_data=16'h1234 at edge N -> from N+1 both ports with rd_addr=3 return 16'h1234; r2 still 0.
3. Bypass: wr_en=1, wr_addr=4, wr_data=16'hA5A5, rd_addr port0=4 in same cycle before edge -> rd_data0=16'hA5A5 combinationally; port1 addr=5 returns old value.
4. Scoreboard: iss_en r6 at edge N -> busy_vec[6]=1 from N+1 and rd_busy=1 for port reading r6; then wr_en r6=16'h0042 -> rd_busy=0 that same cycle, busy_vec[6]=0 after the edge.
5. Simultaneous issue+writeback to r2 at one edge with wr_data=16'h0077 -> r2 holds 16'h0077 and busy_vec[2]=1 after the edge.
6. With REG_FILE_ZERO_REG_EN: wr_en r0=16'hFFFF and iss_en r0 -> rd_data for r0 = 0 (also in the bypass cycle), busy_vec[0]=0; without the macro -> r0 reads 16'hFFFF and busy_vec[0]=1.
